// File: rtl/convolutor_seq_ctrl.sv
// Sequencer and MAC engine for 1-D convolution Z[j] = sum_k X[k]*Y[j-k].
// Generates X/Y reads, pipelines the products and writes one Z sample per output index.
module convolutor_seq_ctrl #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned READ_LAT = 1,
   parameter int unsigned ACC_W    = 2 * DATA_W + ADDR_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic [ADDR_W:0]     size_x_i,
   input  logic [ADDR_W:0]     size_y_i,
   output logic                x_rd_o,
   output logic [ADDR_W-1:0]   x_addr_o,
   input  logic [DATA_W-1:0]   x_data_i,
   output logic                y_rd_o,
   output logic [ADDR_W-1:0]   y_addr_o,
   input  logic [DATA_W-1:0]   y_data_i,
   output logic                z_we_o,
   output logic [ADDR_W:0]     z_addr_o,
   output logic [ACC_W-1:0]    z_data_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o
);

   localparam int unsigned LW  = ADDR_W + 1;
   localparam int unsigned DCW = $clog2(READ_LAT + 2);
   localparam int unsigned PW  = 2 * DATA_W;
   localparam logic [LW-1:0] MAX_LEN = LW'(1) << ADDR_W;

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StLoad  = 3'd1;
   localparam logic [2:0] StIssue = 3'd2;
   localparam logic [2:0] StDrain = 3'd3;
   localparam logic [2:0] StWrite = 3'd4;
   localparam logic [2:0] StDone  = 3'd5;

   logic [2:0]              state;
   logic [LW-1:0]           sx, sy, sz, j, k;
   logic [DCW-1:0]          dcnt;
   logic                    err_flag;
   logic [READ_LAT-1:0]     vld;
   logic                    prod_vld;
   logic signed [ACC_W-1:0] prod_q;
   logic signed [ACC_W-1:0] acc;

   logic                    size_bad;
   logic [LW-1:0]           k_hi, j_nxt, k_lo_nxt;
   logic                    rd;
   logic signed [PW-1:0]    prod;
   logic signed [ACC_W-1:0] prod_ext;

   always_comb begin
      size_bad = (size_x_i == '0) || (size_y_i == '0) ||
                 (size_x_i > MAX_LEN) || (size_y_i > MAX_LEN);
      k_hi     = (j < sx - LW'(1)) ? j : sx - LW'(1);
      j_nxt    = j + LW'(1);
      k_lo_nxt = (j_nxt >= sy) ? (j_nxt - sy + LW'(1)) : '0;
      rd       = (state == StIssue);
      prod     = $signed(x_data_i) * $signed(y_data_i);
      prod_ext = {{(ACC_W - PW){prod[PW-1]}}, prod};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= StIdle;
         sx       <= '0;
         sy       <= '0;
         sz       <= '0;
         j        <= '0;
         k        <= '0;
         dcnt     <= '0;
         err_flag <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (start_i) state <= StLoad;
            end
            StLoad: begin
               sx       <= size_x_i;
               sy       <= size_y_i;
               sz       <= size_x_i + size_y_i - LW'(1);
               j        <= '0;
               k        <= '0;
               err_flag <= size_bad;
               state    <= size_bad ? StDone : StIssue;
            end
            StIssue: begin
               k <= k + LW'(1);
               if (k == k_hi) begin
                  dcnt  <= '0;
                  state <= StDrain;
               end
            end
            StDrain: begin
               dcnt <= dcnt + DCW'(1);
               if (dcnt == DCW'(READ_LAT)) state <= StWrite;
            end
            StWrite: begin
               if (j == sz - LW'(1)) begin
                  state <= StDone;
               end else begin
                  j     <= j_nxt;
                  k     <= k_lo_nxt;
                  state <= StIssue;
               end
            end
            StDone: begin
               err_flag <= 1'b0;
               state    <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

   // Read-valid bits follow each read through the memory latency so only real
   // products reach the accumulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld      <= '0;
         prod_vld <= 1'b0;
         prod_q   <= '0;
         acc      <= '0;
      end else begin
         vld[0] <= rd;
         for (int i = 1; i < READ_LAT; i++) vld[i] <= vld[i-1];
         prod_vld <= vld[READ_LAT-1];
         prod_q   <= vld[READ_LAT-1] ? prod_ext : '0;
         if (state == StLoad || state == StWrite) acc <= '0;
         else if (prod_vld)                        acc <= acc + prod_q;
      end
   end

   always_comb begin
      x_rd_o   = rd;
      y_rd_o   = rd;
      x_addr_o = rd ? ADDR_W'(k) : '0;
      y_addr_o = rd ? ADDR_W'(j - k) : '0;
      z_we_o   = (state == StWrite);
      z_addr_o = z_we_o ? j : '0;
      z_data_o = z_we_o ? acc : '0;
      busy_o   = (state == StLoad) || (state == StIssue) ||
                 (state == StDrain) || (state == StWrite);
      done_o   = (state == StDone);
      err_o    = (state == StDone) && err_flag;
   end

endmodule

// File: tb/tb_convolutor_seq_ctrl.sv
// Bench for convolutor_seq_ctrl: READ_LAT=1 and READ_LAT=2 instances, table of runs,
// reference convolution pushed to per-instance queues and matched against Z writes.
module tb_convolutor_seq_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start1, start2;
   logic [5:0]  size_x, size_y;
   logic signed [7:0] xmem [32];
   logic signed [7:0] ymem [32];

   logic        x1_rd, y1_rd, z1_we, busy1, done1, err1;
   logic [4:0]  x1_addr, y1_addr;
   logic [7:0]  x1_d, y1_d;
   logic [5:0]  z1_addr;
   logic [20:0] z1_data;

   logic        x2_rd, y2_rd, z2_we, busy2, done2, err2;
   logic [4:0]  x2_addr, y2_addr;
   logic [7:0]  x2_s, y2_s, x2_d, y2_d;
   logic [5:0]  z2_addr;
   logic [20:0] z2_data;

   convolutor_seq_ctrl #(.DATA_W(8), .ADDR_W(5), .READ_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst), .start_i(start1), .size_x_i(size_x), .size_y_i(size_y),
      .x_rd_o(x1_rd), .x_addr_o(x1_addr), .x_data_i(x1_d),
      .y_rd_o(y1_rd), .y_addr_o(y1_addr), .y_data_i(y1_d),
      .z_we_o(z1_we), .z_addr_o(z1_addr), .z_data_o(z1_data),
      .busy_o(busy1), .done_o(done1), .err_o(err1));

   convolutor_seq_ctrl #(.DATA_W(8), .ADDR_W(5), .READ_LAT(2)) u_dut2 (
      .clk(clk), .rst(rst), .start_i(start2), .size_x_i(size_x), .size_y_i(size_y),
      .x_rd_o(x2_rd), .x_addr_o(x2_addr), .x_data_i(x2_d),
      .y_rd_o(y2_rd), .y_addr_o(y2_addr), .y_data_i(y2_d),
      .z_we_o(z2_we), .z_addr_o(z2_addr), .z_data_o(z2_data),
      .busy_o(busy2), .done_o(done2), .err_o(err2));

   // Memory models; junk on the bus when no read was issued
   always @(posedge clk) begin
      x1_d <= x1_rd ? xmem[x1_addr] : 8'h5a;
      y1_d <= y1_rd ? ymem[y1_addr] : 8'h5a;
      x2_s <= x2_rd ? xmem[x2_addr] : 8'h5a;
      y2_s <= y2_rd ? ymem[y2_addr] : 8'h5a;
      x2_d <= x2_s;
      y2_d <= y2_s;
   end

   // Observation side: record writes and strobe/idle-value violations
   int oa1 [1024], od1 [1024], oa2 [1024], od2 [1024];
   int zcap1 [64], zcap2 [64];
   int nw1 = 0, nw2 = 0, rdc1 = 0, rdc2 = 0, bad1 = 0, bad2 = 0;

   always @(negedge clk) begin
      if (x1_rd) rdc1++;
      if ((x1_rd != y1_rd) || (!x1_rd && (x1_addr != 0 || y1_addr != 0)) ||
          (!z1_we && (z1_addr != 0 || z1_data != 0)) || (err1 && !done1)) bad1++;
      if (z1_we && nw1 < 1024) begin
         oa1[nw1] = int'(z1_addr);
         od1[nw1] = int'(z1_data);
         zcap1[z1_addr] = int'($signed(z1_data));
         nw1++;
      end
      if (x2_rd) rdc2++;
      if ((x2_rd != y2_rd) || (!x2_rd && (x2_addr != 0 || y2_addr != 0)) ||
          (!z2_we && (z2_addr != 0 || z2_data != 0)) || (err2 && !done2)) bad2++;
      if (z2_we && nw2 < 1024) begin
         oa2[nw2] = int'(z2_addr);
         od2[nw2] = int'(z2_data);
         zcap2[z2_addr] = int'($signed(z2_data));
         nw2++;
      end
   end

   typedef struct { int addr; int data; } zexp_t;
   zexp_t q1 [$];
   zexp_t q2 [$];
   int rp1 = 0, rp2 = 0;
   int n_cmp = 0, n_fail = 0;

   typedef struct { int dut; int sx; int sy; int pat; int hold; int cyc; int err; int spot; } vec_t;
   localparam int NV = 11;
   vec_t vec [NV];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fill(input int pat);
      for (int i = 0; i < 32; i++) begin
         case (pat)
            0: begin xmem[i] = 8'(i + 1); ymem[i] = 8'sd1; end
            1: begin xmem[i] = -8'sd2;    ymem[i] = 8'(i + 1); end
            2: begin xmem[i] = -8'sd128;  ymem[i] = -8'sd128; end
            default: begin xmem[i] = 8'($urandom); ymem[i] = 8'($urandom); end
         endcase
      end
   endtask

   task automatic push_model(input int d, input int sx, input int sy);
      zexp_t e;
      for (int jj = 0; jj < sx + sy - 1; jj++) begin
         int sum = 0;
         for (int kk = 0; kk < sx; kk++)
            if (jj - kk >= 0 && jj - kk < sy) sum += int'(xmem[kk]) * int'(ymem[jj - kk]);
         e.addr = jj;
         e.data = sum & 32'h1fffff;
         if (d == 1) q1.push_back(e); else q2.push_back(e);
      end
   endtask

   task automatic check_writes(input int d, input bit flush);
      zexp_t e;
      int n = (d == 1) ? nw1 : nw2;
      int r = (d == 1) ? rp1 : rp2;
      while (r < n) begin
         if ((d == 1 && q1.size() == 0) || (d == 2 && q2.size() == 0)) begin
            chk("z_unexpected_write", 1, 0);
         end else begin
            e = (d == 1) ? q1.pop_front() : q2.pop_front();
            chk("z_addr", (d == 1) ? oa1[r] : oa2[r], e.addr);
            chk("z_data", (d == 1) ? od1[r] : od2[r], e.data);
         end
         r++;
      end
      if (flush) begin
         if (d == 1) q1.delete(); else q2.delete();
      end else begin
         chk("z_missing_writes", (d == 1) ? q1.size() : q2.size(), 0);
      end
      if (d == 1) rp1 = r; else rp2 = r;
   endtask

   function automatic int outs_nonzero(input int d);
      if (d == 1)
         return int'(|{x1_rd, y1_rd, x1_addr, y1_addr, z1_we, z1_addr, z1_data, busy1, done1, err1});
      return int'(|{x2_rd, y2_rd, x2_addr, y2_addr, z2_we, z2_addr, z2_data, busy2, done2, err2});
   endfunction

   // Caller is #1 past a rising edge; counts cycles from the start-sampling edge
   task automatic run(input int d, input int sx, input int sy, input int hold,
                      input int exp_cyc, input int exp_err);
      int cyc, rd0, we0;
      logic dn;
      size_x = 6'(sx);
      size_y = 6'(sy);
      if (exp_err == 0) push_model(d, sx, sy);
      rd0 = (d == 1) ? rdc1 : rdc2;
      we0 = (d == 1) ? nw1 : nw2;
      if (d == 1) start1 = 1'b1; else start2 = 1'b1;
      @(posedge clk); #1;
      cyc = 1;
      chk("busy_in_load", int'((d == 1) ? busy1 : busy2), 1);
      if (hold == 0) begin start1 = 1'b0; start2 = 1'b0; end
      dn = (d == 1) ? done1 : done2;
      while (!dn && cyc < 4000) begin
         @(posedge clk); #1;
         cyc++;
         dn = (d == 1) ? done1 : done2;
      end
      start1 = 1'b0;
      start2 = 1'b0;
      chk("done_cycle", cyc, exp_cyc);
      chk("err_with_done", int'((d == 1) ? err1 : err2), exp_err);
      chk("busy_low_in_done", int'((d == 1) ? busy1 : busy2), 0);
      @(posedge clk); #1;
      chk("done_single_pulse", int'((d == 1) ? done1 : done2), 0);
      if (exp_err != 0) begin
         chk("err_no_reads", ((d == 1) ? rdc1 : rdc2) - rd0, 0);
         chk("err_no_writes", ((d == 1) ? nw1 : nw2) - we0, 0);
      end
      check_writes(d, 1'b0);
   endtask

   task automatic spot_t1(input int d);
      int ref_z [5];
      ref_z = '{1, 3, 6, 5, 3};
      for (int i = 0; i < 5; i++) chk("t1_z", (d == 1) ? zcap1[i] : zcap2[i], ref_z[i]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cyc, snap;
      vec[0]  = '{1, 3, 3, 0, 0, 26, 0, 1};
      vec[1]  = '{1, 1, 4, 1, 1, 18, 0, 2};
      vec[2]  = '{1, 32, 32, 2, 0, 1215, 0, 3};
      vec[3]  = '{1, 0, 3, 0, 0, 2, 1, 0};
      vec[4]  = '{1, 33, 3, 0, 0, 2, 1, 0};
      vec[5]  = '{1, 3, 0, 0, 0, 2, 1, 0};
      vec[6]  = '{1, 5, 32, 3, 0, 270, 0, 0};
      vec[7]  = '{2, 3, 3, 0, 0, 31, 0, 1};
      vec[8]  = '{2, 4, 7, 3, 0, 70, 0, 0};
      vec[9]  = '{1, 32, 1, 3, 0, 130, 0, 0};
      vec[10] = '{2, 3, 33, 0, 0, 2, 1, 0};

      rst = 1'b1; start1 = 1'b0; start2 = 1'b0; size_x = '0; size_y = '0;
      fill(0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs_dut1", outs_nonzero(1), 0);
      chk("reset_outputs_dut2", outs_nonzero(2), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < NV; i++) begin
         fill(vec[i].pat);
         run(vec[i].dut, vec[i].sx, vec[i].sy, vec[i].hold, vec[i].cyc, vec[i].err);
         case (vec[i].spot)
            1: spot_t1(vec[i].dut);
            2: for (int jj = 0; jj < 4; jj++) chk("t2_z", zcap1[jj], -2 * (jj + 1));
            3: begin
               chk("t3_z0", zcap1[0], 16384);
               chk("t3_z31", zcap1[31], 524288);
               chk("t3_z62", zcap1[62], 16384);
            end
            default: ;
         endcase
      end

      // Reset during ISSUE of j=2 with products in flight, then rerun
      fill(0);
      size_x = 6'd3;
      size_y = 6'd3;
      push_model(1, 3, 3);
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      cyc = 0;
      while (nw1 - rp1 < 2 && cyc < 200) begin @(posedge clk); #1; cyc++; end
      cyc = 0;
      while (!x1_rd && cyc < 200) begin @(posedge clk); #1; cyc++; end
      @(posedge clk); #1;
      chk("t5_in_issue", int'(x1_rd), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t5_outputs_after_rst", outs_nonzero(1), 0);
      snap = nw1;
      repeat (8) @(posedge clk);
      #1;
      chk("t5_no_write_after_rst", nw1, snap);
      chk("t5_idle_after_rst", int'(busy1), 0);
      check_writes(1, 1'b1);
      for (int i = 0; i < 5; i++) zcap1[i] = 0;
      run(1, 3, 3, 0, 26, 0);
      spot_t1(1);

      chk("strobe_idle_values_dut1", bad1, 0);
      chk("strobe_idle_values_dut2", bad2, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
